// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and ALU strobe map shared by alu_cmd_sequencer (ALU_SEQ_REPEAT_EN adds S_REPEAT)
package alu_seq_pkg;
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MULT = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8, OP_ON = 4'd9, OP_OFF = 4'd10, OP_CLR = 4'd11;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_SEQ_REPEAT_EN
    S_REPEAT = 2'd2,
`endif
    S_ISSUE = 2'd1
  } state_t;
  localparam int SB_MULT = 0, SB_ADD = 1, SB_SUB = 2, SB_ANDD = 3, SB_ORR = 4;
  localparam int SB_XORR = 5, SB_NOTT = 6, SB_LOAD = 7, SB_ON = 8, SB_OFF = 9;
  function automatic logic [9:0] op_strobe(input logic [3:0] op);
    op_strobe = '0;
    op_strobe[SB_MULT] = op == OP_MULT;
    op_strobe[SB_ADD] = op == OP_ADD;
    op_strobe[SB_SUB] = op == OP_SUB;
    op_strobe[SB_ANDD] = op == OP_AND;
    op_strobe[SB_ORR] = op == OP_OR;
    op_strobe[SB_XORR] = op == OP_XOR;
    op_strobe[SB_NOTT] = op == OP_NOT;
    op_strobe[SB_LOAD] = op == OP_LOAD;
    op_strobe[SB_ON] = op == OP_ON;
    op_strobe[SB_OFF] = op == OP_OFF;
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous wrap-around command FIFO with occupancy count
module alu_cmd_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int A = $clog2(DEPTH);
  localparam int L = A + 1;
  logic [W-1:0] mem [DEPTH];
  logic [A-1:0] wp, rp;
  logic wr, rd;
  assign full = level[A];
  assign empty = level == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + A'(wr);
      rp <= rp + A'(rd);
      level <= level + L'(wr) - L'(rd);
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered one-hot command issue to the accumulator ALU with tagged result capture; ALU_SEQ_REPEAT_EN adds per-command repeat
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [N-1:0]           cmd_data,
`ifdef ALU_SEQ_REPEAT_EN
  input  logic [3:0]             cmd_rep,
`endif
  output logic [N-1:0]           alu_in,
  output logic                   alu_add,
  output logic                   alu_sub,
  output logic                   alu_mult,
  output logic                   alu_andd,
  output logic                   alu_orr,
  output logic                   alu_nott,
  output logic                   alu_xorr,
  output logic                   alu_load,
  output logic                   alu_on,
  output logic                   alu_off,
  output logic                   alu_rst,
  input  logic [N-1:0]           alu_out,
  output logic                   res_valid,
  output logic [N-1:0]           res_data,
  output logic [3:0]             res_op,
  output logic                   pwr,
  output logic                   err,
  output logic [$clog2(DEPTH):0] level
);
`ifdef ALU_SEQ_REPEAT_EN
  localparam int W = N + 8;
`else
  localparam int W = N + 4;
`endif
  state_t state, state_n;
  logic [W-1:0] wdata, rdata;
  logic full, empty, pop, issue, legal, busy;
  logic [9:0] strobe;
  logic [3:0] cur_op, head_op;
  logic [N-1:0] head_data;
  assign cmd_ready = !full;
  assign head_op = rdata[N+3:N];
  assign head_data = rdata[N-1:0];
  assign legal = head_op <= OP_CLR;
  assign busy = state != S_IDLE;
  assign {alu_off, alu_on, alu_load, alu_nott, alu_xorr, alu_orr, alu_andd, alu_sub, alu_add, alu_mult} = strobe;
`ifdef ALU_SEQ_REPEAT_EN
  logic [3:0] rcnt, rem;
  logic last;
  assign wdata = {cmd_rep, cmd_op, cmd_data};
  assign rem = state == S_REPEAT ? rcnt : rdata[W-1:N+4];
  assign last = !legal || rem == 4'd0;
  always_ff @(posedge clk)
    rcnt <= !rst ? 4'd0 : state_n == S_REPEAT ? rem - 4'd1 : rcnt;
`else
  assign wdata = {cmd_op, cmd_data};
`endif
  alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(cmd_valid), .pop(pop), .wdata(wdata), .rdata(rdata),
    .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge clk)
    state <= !rst ? S_IDLE : state_n;
  always_comb begin
    issue = !empty && legal;
`ifdef ALU_SEQ_REPEAT_EN
    pop = !empty && last;
    state_n = !issue ? S_IDLE : last ? S_ISSUE : S_REPEAT;
`else
    pop = !empty;
    state_n = issue ? S_ISSUE : S_IDLE;
`endif
  end
  always_ff @(posedge clk)
    if (!rst) begin
      strobe <= '0;
      alu_in <= '0;
      alu_rst <= 1'b1;
      cur_op <= OP_NOP;
      res_valid <= 1'b0;
      res_data <= '0;
      res_op <= '0;
      pwr <= 1'b1;
      err <= 1'b0;
    end else begin
      strobe <= issue ? op_strobe(head_op) : '0;
      alu_rst <= issue && head_op == OP_CLR;
      alu_in <= issue ? head_data : alu_in;
      cur_op <= issue ? head_op : cur_op;
      res_valid <= busy;
      res_data <= busy ? alu_out : res_data;
      res_op <= busy ? cur_op : res_op;
      pwr <= !busy ? pwr : cur_op == OP_OFF ? 1'b0 : (cur_op == OP_ON || cur_op == OP_CLR) ? 1'b1 : pwr;
      err <= err || (!empty && !legal);
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with an accumulator ALU stub for alu_cmd_sequencer (ALU_SEQ_REPEAT_EN adds repeat/full tests)
module tb_alu_cmd_sequencer;
  localparam logic [3:0] NOP = 0, ADD = 1, SUB = 2, MULT = 3, AND = 4, OR = 5, XOR = 6, NOT = 7;
  localparam logic [3:0] LOAD = 8, ON = 9, OFF = 10, CLR = 11;
  logic clk = 0, rst = 0, cmd_valid = 0;
  logic [3:0] cmd_op = 0;
  logic [7:0] cmd_data = 0;
`ifdef ALU_SEQ_REPEAT_EN
  logic [3:0] cmd_rep = 0;
`endif
  logic cmd_ready, alu_add, alu_sub, alu_mult, alu_andd, alu_orr, alu_nott, alu_xorr, alu_load, alu_on, alu_off;
  logic alu_rst, res_valid, pwr, err;
  logic [7:0] alu_in, res_data, aout;
  logic [3:0] res_op;
  logic [2:0] level;
  logic [7:0] acc = 0;
  logic apwr = 1;
  logic [7:0] acc_m = 0;
  logic pw_m = 1;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  int vectors = 0, miscompares = 0;
  wire [9:0] sb = {alu_off, alu_on, alu_load, alu_nott, alu_xorr, alu_orr, alu_andd, alu_sub, alu_add, alu_mult};
  always #5 clk = ~clk;
  alu_cmd_sequencer #(.N(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
`ifdef ALU_SEQ_REPEAT_EN
    .cmd_rep(cmd_rep),
`endif
    .alu_in(alu_in), .alu_add(alu_add), .alu_sub(alu_sub), .alu_mult(alu_mult), .alu_andd(alu_andd),
    .alu_orr(alu_orr), .alu_nott(alu_nott), .alu_xorr(alu_xorr), .alu_load(alu_load), .alu_on(alu_on),
    .alu_off(alu_off), .alu_rst(alu_rst), .alu_out(aout), .res_valid(res_valid), .res_data(res_data),
    .res_op(res_op), .pwr(pwr), .err(err), .level(level)
  );
  always_comb begin
    aout = acc;
    if (alu_rst) aout = '0;
    else if (apwr) begin
      if (alu_add) aout = acc + alu_in;
      if (alu_sub) aout = acc - alu_in;
      if (alu_mult) aout = acc * alu_in;
      if (alu_andd) aout = acc & alu_in;
      if (alu_orr) aout = acc | alu_in;
      if (alu_xorr) aout = acc ^ alu_in;
      if (alu_nott) aout = ~acc;
      if (alu_load) aout = alu_in;
    end
  end
  always @(posedge clk)
    if (alu_rst) begin
      acc <= '0;
      apwr <= 1'b1;
    end else begin
      acc <= aout;
      if (alu_on) apwr <= 1'b1;
      if (alu_off) apwr <= 1'b0;
    end
  always @(negedge clk)
    if (res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result res_op=%0d res_data=%0d, no result expected", res_op, res_data);
      end else begin
        e = exp_q.pop_front();
        vectors += 2;
        if (res_op !== e[11:8]) begin
          miscompares++;
          $display("FAIL res_op got %0d want %0d", res_op, e[11:8]);
        end
        if (res_data !== e[7:0]) begin
          miscompares++;
          $display("FAIL res_data op=%0d got %0d want %0d", e[11:8], res_data, e[7:0]);
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [3:0] op, input logic [7:0] d);
    logic [7:0] r;
    r = acc_m;
    if (op == CLR) begin
      r = 0;
      pw_m = 1;
    end else if (op == ON) pw_m = 1;
    else if (op == OFF) pw_m = 0;
    else if (pw_m)
      case (op)
        ADD: r = acc_m + d;
        SUB: r = acc_m - d;
        MULT: r = acc_m * d;
        AND: r = acc_m & d;
        OR: r = acc_m | d;
        XOR: r = acc_m ^ d;
        NOT: r = ~acc_m;
        LOAD: r = d;
        default: r = acc_m;
      endcase
    acc_m = r;
    exp_q.push_back({op, r});
  endtask
  task automatic push(input logic [3:0] op, input logic [7:0] d, input int rep = 0);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
`ifdef ALU_SEQ_REPEAT_EN
    cmd_rep = rep[3:0];
`endif
    for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) tick();
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_ready got %b want 1", cmd_ready);
    end
    if (op <= CLR)
      for (int i = 0; i <= rep; i++) model(op, d);
    tick();
    cmd_valid = 0;
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    tick();
    tick();
  endtask
  task automatic test_reset();
    rst = 0;
    tick();
    tick();
    vectors++;
    if ({alu_rst, res_valid, level, pwr, err, sb, alu_in, res_data, res_op, cmd_ready} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 10'd0, 8'd0, 8'd0, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state alu_rst=%b res_valid=%b level=%0d pwr=%b err=%b sb=%h alu_in=%0d res_data=%0d res_op=%0d ready=%b",
               alu_rst, res_valid, level, pwr, err, sb, alu_in, res_data, res_op, cmd_ready);
    end
    rst = 1;
    tick();
    vectors++;
    if ({alu_rst, res_valid, level, pwr} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_release alu_rst=%b res_valid=%b level=%0d pwr=%b want 0 0 0 1", alu_rst, res_valid, level, pwr);
    end
    acc_m = 0;
    pw_m = 1;
    tick();
  endtask
  task automatic test_latency();
    push(LOAD, 8'd9);
    vectors++;
    if ({level, sb, res_valid} !== {3'd1, 10'h000, 1'b0}) begin
      miscompares++;
      $display("FAIL lat_e0 level=%0d sb=%h res_valid=%b want 1 000 0", level, sb, res_valid);
    end
    tick();
    vectors++;
    if ({level, sb, alu_in, res_valid} !== {3'd0, 10'h080, 8'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL lat_e1 level=%0d sb=%h alu_in=%0d res_valid=%b want 0 080 9 0", level, sb, alu_in, res_valid);
    end
    tick();
    vectors++;
    if ({sb, res_valid, res_data} !== {10'h000, 1'b1, 8'd9}) begin
      miscompares++;
      $display("FAIL lat_e2 sb=%h res_valid=%b res_data=%0d want 000 1 9", sb, res_valid, res_data);
    end
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_e3 res_valid=%b want 0", res_valid);
    end
    wait_drain();
  endtask
  task automatic test_back_to_back();
    logic [3:0] ops[4] = '{LOAD, ADD, MULT, SUB};
    logic [7:0] ds[4] = '{8'd5, 8'd3, 8'd4, 8'd2};
    for (int k = 0; k < 4; k++) begin
      push(ops[k], ds[k]);
      vectors++;
      if ({level, res_valid} !== {3'd1, k >= 2}) begin
        miscompares++;
        $display("FAIL b2b_push%0d level=%0d res_valid=%b want 1 %b", k, level, res_valid, k >= 2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (res_valid !== (k < 2)) begin
        miscompares++;
        $display("FAIL b2b_tail%0d res_valid=%b want %b", k, res_valid, k < 2);
      end
    end
    wait_drain();
    vectors++;
    if (res_data !== 8'd30) begin
      miscompares++;
      $display("FAIL b2b_final res_data=%0d want 30", res_data);
    end
  endtask
  task automatic test_logic();
    logic [3:0] ops[9] = '{LOAD, AND, OR, XOR, NOT, NOP, SUB, MULT, ADD};
    logic [7:0] ds[9] = '{8'hF0, 8'h3C, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h40, 8'h10, 8'hC0};
    for (int k = 0; k < 9; k++) push(ops[k], ds[k]);
    wait_drain();
    vectors++;
    if (res_data !== 8'h10) begin
      miscompares++;
      $display("FAIL logic_final res_data=%h want 10", res_data);
    end
  endtask
  task automatic test_illegal();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_before got %b want 0", err);
    end
    push(CLR, 8'd0);
    push(ADD, 8'd1);
    push(4'd13, 8'd77);
    push(ADD, 8'd1);
    wait_drain();
    vectors++;
    if ({err, res_data, res_op} !== {1'b1, 8'd2, ADD}) begin
      miscompares++;
      $display("FAIL illegal err=%b res_data=%0d res_op=%0d want 1 2 1", err, res_data, res_op);
    end
    repeat (3) tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got %b want 1", err);
    end
  endtask
  task automatic test_power();
    push(LOAD, 8'd8);
    push(OFF, 8'd0);
    push(ADD, 8'd7);
    wait_drain();
    vectors++;
    if ({pwr, res_data} !== {1'b0, 8'd8}) begin
      miscompares++;
      $display("FAIL power_off pwr=%b res_data=%0d want 0 8", pwr, res_data);
    end
    push(ON, 8'd0);
    push(ADD, 8'd7);
    wait_drain();
    vectors++;
    if ({pwr, res_data} !== {1'b1, 8'd15}) begin
      miscompares++;
      $display("FAIL power_on pwr=%b res_data=%0d want 1 15", pwr, res_data);
    end
  endtask
`ifdef ALU_SEQ_REPEAT_EN
  task automatic test_repeat();
    push(CLR, 8'd0);
    push(ADD, 8'd1, 3);
    wait_drain();
    vectors++;
    if (res_data !== 8'd4) begin
      miscompares++;
      $display("FAIL repeat_final res_data=%0d want 4", res_data);
    end
  endtask
  task automatic test_full();
    push(CLR, 8'd0, 7);
    for (int k = 0; k < 3; k++) push(NOP, 8'd0);
    vectors++;
    if ({level, cmd_ready} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL full level=%0d cmd_ready=%b want 4 0", level, cmd_ready);
    end
    cmd_valid = 1;
    cmd_op = NOP;
    cmd_rep = 0;
    tick();
    vectors++;
    if ({level, cmd_ready} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL full_reject level=%0d cmd_ready=%b want 4 0", level, cmd_ready);
    end
    push(NOP, 8'd0);
    vectors++;
    if (level !== 3'd3) begin
      miscompares++;
      $display("FAIL push_pop_level got %0d want 3", level);
    end
    wait_drain();
  endtask
`endif
  task automatic test_reset_mid();
    push(ADD, 8'd1);
    push(ADD, 8'd2);
    push(ADD, 8'd3);
    rst = 0;
    tick();
    vectors++;
    if ({res_valid, level, sb, alu_in, err, pwr, alu_rst} !== {1'b0, 3'd0, 10'd0, 8'd0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset res_valid=%b level=%0d sb=%h alu_in=%0d err=%b pwr=%b alu_rst=%b",
               res_valid, level, sb, alu_in, err, pwr, alu_rst);
    end
    exp_q.delete();
    acc_m = 0;
    pw_m = 1;
    rst = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({res_valid, level, sb} !== {1'b0, 3'd0, 10'd0}) begin
        miscompares++;
        $display("FAIL mid_quiet%0d res_valid=%b level=%0d sb=%h want 0 0 000", k, res_valid, level, sb);
      end
    end
    push(ADD, 8'd4);
    wait_drain();
    vectors++;
    if (res_data !== 8'd4) begin
      miscompares++;
      $display("FAIL mid_after res_data=%0d want 4", res_data);
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_logic();
    test_illegal();
    test_power();
`ifdef ALU_SEQ_REPEAT_EN
    test_repeat();
    test_full();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
